// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: instruction fetch and data load/store share one
// memory port, with a starvation bound on the instruction side and checks on
// data access legality.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 3,
  parameter int DATA_LIMIT = 1024,
  localparam int CW = (STARVE_MAX < 4) ? 2 : $clog2(STARVE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [11:0]   if_addr,
  output logic          if_ack,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [11:0]   d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [2:0]    d_f3,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_sel,
  output logic [11:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [2:0]    mem_f3,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [31:0]   mem_rdata,
  output logic          stall_if,
  output logic [1:0]    dbg_state,
  output logic [CW-1:0] dbg_starve
);

  // Handshake: a requester holds req (and its address/data) until it sees
  // ack=1; the transfer completes at that rising edge and the requester may
  // change or drop the request from the next cycle on.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DACC   = 2'd2
  } state_t;

  localparam logic [2:0]    F3_B  = 3'b000;
  localparam logic [2:0]    F3_H  = 3'b001;
  localparam logic [2:0]    F3_W  = 3'b010;
  localparam logic [2:0]    F3_BU = 3'b100;
  localparam logic [2:0]    F3_HU = 3'b101;
  localparam logic [CW-1:0] SMAX  = CW'(STARVE_MAX);

  state_t        state, state_n;
  logic [CW-1:0] starve_cnt, starve_cnt_n;
  logic [2:0]    size;
  logic          legal_f3;
  logic [12:0]   end_addr;
  logic          err;

  always_comb begin
    legal_f3 = 1'b1;
    size     = 3'd1;
    case (d_f3)
      F3_B, F3_BU: size = 3'd1;
      F3_H, F3_HU: size = 3'd2;
      F3_W:        size = 3'd4;
      default: begin
        legal_f3 = 1'b0;
        size     = 3'd1;
      end
    endcase
  end

  // 13-bit sum so an access running off the top of the 12-bit space is caught.
  assign end_addr = {1'b0, d_addr} + {10'd0, size};
  assign err = !legal_f3
             || (size == 3'd2 && d_addr[0])
             || (size == 3'd4 && d_addr[1:0] != 2'b00)
             || ({19'd0, end_addr} > 32'(DATA_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    starve_cnt_n = starve_cnt;
    case (state)
      IDLE: begin
        if (d_req && (!if_req || starve_cnt < SMAX)) begin
          state_n = DACC;
          if (if_req)
            starve_cnt_n = (starve_cnt == SMAX) ? starve_cnt : starve_cnt + 1'b1;
          else
            starve_cnt_n = '0;
        end else if (if_req) begin
          state_n      = IFETCH;
          starve_cnt_n = '0;
        end else begin
          starve_cnt_n = '0;
        end
      end
      IFETCH:  state_n = IDLE;
      DACC:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Memory-side outputs; reset forces the idle values so an in-flight
  // store is dropped rather than written.
  always_comb begin
    mem_sel   = 1'b0;
    mem_addr  = 12'd0;
    mem_wdata = 32'd0;
    mem_f3    = 3'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    if (!rst) begin
      case (state)
        IFETCH: begin
          mem_sel  = 1'b1;
          mem_addr = if_addr;
          if_ack   = 1'b1;
        end
        DACC: begin
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          mem_f3    = d_f3;
          mem_read  = !d_we && !err;
          mem_write = d_we && !err;
          d_ack     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata <= 32'd0;
      d_rdata  <= 32'd0;
      d_err    <= 1'b0;
    end else begin
      if (state == IFETCH)
        if_rdata <= mem_rdata;
      if (state == DACC) begin
        d_err <= err;
        if (!d_we && !err)
          d_rdata <= mem_rdata;
      end
    end
  end

  assign stall_if   = if_req && !if_ack;
  assign dbg_state  = state;
  assign dbg_starve = starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized
// traffic checked against a transaction-level model of arbitration and data.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 3;
  localparam int DATA_LIMIT = 1024;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [11:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [11:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_f3;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_sel;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_f3;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_starve;

  int checks   = 0;
  int failures = 0;

  // Environment memories: instruction image is fixed, data memory is only
  // written by the DUT's mem_write strobe.
  logic [31:0] imem [0:1023];
  logic [31:0] dmem [0:1023] = '{default: 32'h0};
  // Reference copy of data memory, updated from the bench's own transactions.
  logic [31:0] shadow [0:1023] = '{default: 32'h0};

  logic [31:0] exp_ir;
  logic [31:0] exp_dr;
  logic        exp_de;

  always #5 clk = ~clk;

  assign mem_rdata = mem_sel ? imem[mem_addr[11:2]] : dmem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_write)
      dmem[mem_addr[11:2]] <= mem_wdata;
  end

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .DATA_LIMIT(DATA_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_f3(d_f3),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_f3(mem_f3),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .dbg_state(dbg_state), .dbg_starve(dbg_starve)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Legality of a data access, straight from the size/alignment/limit rules.
  function automatic logic model_err(input logic [2:0] f3, input logic [11:0] a);
    int sz;
    case (f3)
      LB, LBU: sz = 1;
      LH, LHU: sz = 2;
      LW:      sz = 4;
      default: return 1'b1;
    endcase
    if (int'(a) % sz != 0) return 1'b1;
    if (int'(a) + sz > DATA_LIMIT) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  // Presents one data request, waits for its ack, then drops it.
  task automatic data_xfer(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                           input logic [31:0] wdata, input logic exp_err);
    bit got = 0;
    d_req = 1'b1; d_we = we; d_f3 = f3; d_addr = addr; d_wdata = wdata;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      check1("xfer_mem_write", mem_write, d_ack && we && !exp_err);
      if (d_ack) begin
        got = 1;
        check("xfer_mem_addr", 32'(mem_addr), 32'(addr));
        check1("xfer_mem_read", mem_read, !we && !exp_err);
        check1("xfer_mem_sel", mem_sel, 1'b0);
        check("xfer_mem_f3", 32'(mem_f3), 32'(f3));
        if (we) check("xfer_mem_wdata", mem_wdata, wdata);
      end else begin
        drive_point();
      end
    end
    if (!got) check1("xfer_timeout", 1'b0, 1'b1);
    drive_point();
    d_req = 1'b0; d_we = 1'b0;
  endtask

  // Full data case: transfer plus the registered result in the next cycle.
  task automatic data_case(input string tag, input logic we, input logic [2:0] f3,
                           input logic [11:0] addr, input logic [31:0] wdata,
                           input logic exp_err);
    data_xfer(we, f3, addr, wdata, exp_err);
    if (!exp_err) begin
      if (we) shadow[addr[11:2]] = wdata;
      else    exp_dr = shadow[addr[11:2]];
    end
    exp_de = exp_err;
    @(negedge clk);
    check({tag, "_d_err"}, 32'(d_err), 32'(exp_de));
    check({tag, "_d_rdata"}, d_rdata, exp_dr);
    drive_point();
  endtask

  initial begin
    string       exp_seq;
    logic [7:0]  g;
    logic        prev_ack, prev_idle_req, prev_idle_d, prev_if;
    logic        saw_if, saw_d;
    int          starve_seen;
    logic [2:0]  f3_tab [0:6];

    for (int i = 0; i < 1024; i++)
      imem[i] = (32'(i) * 32'h01010101) ^ 32'hA500_0000;
    imem[1] = 32'h0000_2083;

    rst = 1'b1; if_req = 1'b0; if_addr = 12'd0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 12'd0; d_wdata = 32'hFFFF_FFFF; d_f3 = LW;

    // Reset: registered state cleared, combinational outputs idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_starve", 32'(dbg_starve), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check1("rst_d_err", d_err, 1'b0);
    check1("rst_d_ack", d_ack, 1'b0);
    check1("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    exp_ir = 32'd0; exp_dr = 32'd0; exp_de = 1'b0;

    // Instruction fetch of 0x004.
    drive_point();
    rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_req = 1'b1; if_addr = 12'h004;
    @(negedge clk);
    check1("if_c1_ack", if_ack, 1'b0);
    check1("if_c1_stall", stall_if, 1'b1);
    drive_point();
    @(negedge clk);
    check1("if_c2_ack", if_ack, 1'b1);
    check("if_c2_state", 32'(dbg_state), 32'd1);
    check1("if_c2_sel", mem_sel, 1'b1);
    check("if_c2_addr", 32'(mem_addr), 32'h004);
    check1("if_c2_read", mem_read, 1'b0);
    check1("if_c2_stall", stall_if, 1'b0);
    drive_point();
    if_req = 1'b0;
    @(negedge clk);
    check("if_c3_rdata", if_rdata, 32'h0000_2083);
    check1("if_c3_ack", if_ack, 1'b0);
    drive_point();

    // Store then load, error cases and size/limit boundaries.
    data_case("sw_00c", 1'b1, LW, 12'h00C, 32'h22, 1'b0);
    data_case("lw_00c", 1'b0, LW, 12'h00C, 32'h0, 1'b0);
    check("lw_00c_value", d_rdata, 32'h22);
    data_case("lw_006", 1'b0, LW, 12'h006, 32'h0, 1'b1);
    data_case("sw_3fe", 1'b1, LW, 12'h3FE, 32'hDEAD_BEEF, 1'b1);
    data_case("sw_3fc", 1'b1, LW, 12'h3FC, 32'h1234_5678, 1'b0);
    data_case("lw_3fc", 1'b0, LW, 12'h3FC, 32'h0, 1'b0);
    data_case("lh_3ff", 1'b0, LH, 12'h3FF, 32'h0, 1'b1);
    data_case("lb_3ff", 1'b0, LB, 12'h3FF, 32'h0, 1'b0);
    data_case("lhu_3fe", 1'b0, LHU, 12'h3FE, 32'h0, 1'b0);
    data_case("f3_bad", 1'b0, 3'b011, 12'h000, 32'h0, 1'b1);
    data_case("lbu_400", 1'b0, LBU, 12'h400, 32'h0, 1'b1);
    data_case("lhu_fff", 1'b0, LHU, 12'hFFE, 32'h0, 1'b1);
    data_case("lw_00c_b", 1'b0, LW, 12'h00C, 32'h0, 1'b0);

    // Both requests held: data wins STARVE_MAX times, then the fetch.
    if_req = 1'b1; if_addr = 12'h008;
    d_req = 1'b1; d_we = 1'b0; d_f3 = LW; d_addr = 12'h00C;
    exp_seq = "-D-D-D-I-D-D-D-I";
    for (int i = 0; i < exp_seq.len(); i++) begin
      @(negedge clk);
      g = if_ack ? 8'h49 : (d_ack ? 8'h44 : 8'h2D);
      check($sformatf("grant_seq_%0d", i), 32'(g), 32'(exp_seq[i]));
      if (i != exp_seq.len() - 1) drive_point();
    end
    drive_point();
    if_req = 1'b0; d_req = 1'b0;
    exp_ir = imem[2];
    @(negedge clk);
    check("grant_seq_if_rdata", if_rdata, exp_ir);
    drive_point();

    // Reset pulsed during the DACC cycle of a store.
    if_req = 1'b1; if_addr = 12'h000;
    d_req = 1'b1; d_we = 1'b1; d_f3 = LW; d_addr = 12'h010; d_wdata = 32'h55;
    @(negedge clk);
    check1("rstd_c1_ack", d_ack, 1'b0);
    drive_point();
    rst = 1'b1;
    @(negedge clk);
    check("rstd_state_dacc", 32'(dbg_state), 32'd2);
    check("rstd_starve_pre", 32'(dbg_starve), 32'd1);
    check1("rstd_mem_write", mem_write, 1'b0);
    check1("rstd_d_ack", d_ack, 1'b0);
    drive_point();
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check("rstd_state", 32'(dbg_state), 32'd0);
    check("rstd_starve", 32'(dbg_starve), 32'd0);
    check("rstd_if_rdata", if_rdata, 32'd0);
    check("rstd_d_rdata", d_rdata, 32'd0);
    check1("rstd_d_err", d_err, 1'b0);
    check("rstd_no_store", dmem[4], 32'd0);
    exp_ir = 32'd0; exp_dr = 32'd0; exp_de = 1'b0;
    drive_point();

    // Randomized traffic against the transaction-level model.
    f3_tab[0] = LB; f3_tab[1] = LH; f3_tab[2] = LW; f3_tab[3] = LBU;
    f3_tab[4] = LHU; f3_tab[5] = 3'b011; f3_tab[6] = LW;
    prev_ack = 1'b0; prev_idle_req = 1'b0; prev_idle_d = 1'b0; prev_if = 1'b0;
    starve_seen = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = 12'($urandom_range(0, 1023) * 4);
      end
      if (!d_req && $urandom_range(0, 1) == 0) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_f3    = f3_tab[$urandom_range(0, 6)];
        d_wdata = $urandom;
        case ($urandom_range(0, 3))
          0:       d_addr = 12'($urandom_range(0, 15) * 4);
          1:       d_addr = 12'($urandom_range(0, 4095));
          2:       d_addr = 12'($urandom_range(1016, 1030));
          default: d_addr = 12'($urandom_range(0, 63));
        endcase
      end
      @(negedge clk);
      check("rnd_if_rdata", if_rdata, exp_ir);
      check("rnd_d_rdata", d_rdata, exp_dr);
      check1("rnd_d_err", d_err, exp_de);
      check1("rnd_stall_if", stall_if, if_req && !if_ack);
      check1("rnd_one_grant", if_ack && d_ack, 1'b0);
      check1("rnd_gap", prev_ack && (if_ack || d_ack), 1'b0);
      if (prev_idle_req) check1("rnd_work_conserve", if_ack || d_ack, 1'b1);
      if (prev_idle_d && (!prev_if || starve_seen < STARVE_MAX))
        check1("rnd_data_priority", d_ack, 1'b1);
      saw_if = if_ack;
      saw_d  = d_ack;
      if (if_ack) begin
        check1("rnd_if_sel", mem_sel, 1'b1);
        check("rnd_if_addr", 32'(mem_addr), 32'(if_addr));
        exp_ir = imem[if_addr[11:2]];
        starve_seen = 0;
      end
      if (d_ack) begin
        exp_de = model_err(d_f3, d_addr);
        check("rnd_d_addr", 32'(mem_addr), 32'(d_addr));
        check1("rnd_d_write", mem_write, d_we && !exp_de);
        check1("rnd_d_read", mem_read, !d_we && !exp_de);
        if (prev_if) begin
          starve_seen++;
          check1("rnd_starve_bound", starve_seen <= STARVE_MAX, 1'b1);
        end
        if (!exp_de) begin
          if (d_we) shadow[d_addr[11:2]] = d_wdata;
          else      exp_dr = shadow[d_addr[11:2]];
        end
      end else begin
        check1("rnd_no_write", mem_write, 1'b0);
      end
      prev_ack      = saw_if || saw_d;
      prev_idle_req = !prev_ack && (if_req || d_req);
      prev_idle_d   = !prev_ack && d_req;
      prev_if       = if_req;
      drive_point();
      if (saw_if) if_req = 1'b0;
      if (saw_d)  begin d_req = 1'b0; d_we = 1'b0; end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
